demux48_stream: RTL and testbench
=================================

# demux48_stream

Registered 1-to-4 byte distributor: the write-side counterpart of the 4:1 8-bit selector. One 8-bit input stream with valid/ready handshake is steered by a 2-bit select to one of four output channels. Each channel has its own small FIFO, so a stalled consumer blocks only traffic addressed to it. The block sits between a single byte producer and four independent byte consumers.

## Interface
- DEPTH, 2: entries per channel FIFO; power of two; minimum 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- d  in  8  input byte.
- s  in  2  destination channel for d; sampled together with d.
- in_valid  in  1  producer offers d/s this cycle.
- in_ready  out  1  block accepts d/s this cycle.
- y0, y1, y2, y3  out  8 each  head byte of channel 0..3 FIFO.
- y_valid  out  4  bit i set: channel i holds data.
- y_ready  in  4  bit i set: consumer i takes yi this cycle.
- cnt0..cnt3  out  16 each  per-channel accepted-byte counters; present only with DEMUX48_STATS_EN.

## Operation
- Push: when in_valid && in_ready, d is written to the tail of FIFO[s].
- in_ready = !full[s]. It depends combinationally on s and registered FIFO state only, never on y_ready. There is no pass-through path.
- Pop: when y_valid[i] && y_ready[i], the head of FIFO i is removed. Pops on all four channels are independent and may happen in the same cycle.
- Full FIFO: the push is refused (in_ready=0), even when that channel pops in the same cycle. The producer holds d/s.
- Empty FIFO: y_valid[i]=0 and y_ready[i] is ignored. yi is don't-care but must not be X after reset; it holds the last storage value.
- Simultaneous push and pop on the same non-full, non-empty channel: occupancy is unchanged and order is preserved.
- Push and pop on different channels never interact.
- Occupancy is tracked with (log2(DEPTH)+1)-bit read/write pointers. Pointers wrap modulo 2*DEPTH.
  - full when the pointers' MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
- Data order within a channel is strictly FIFO. There is no ordering guarantee across channels.
- Changing s while in_valid=1 and in_ready=0 is allowed. in_ready then re-evaluates against the new destination.

## Timing
- Reset values: y_valid=4'b0000, y0..y3=8'h00, all pointers 0, cnt0..cnt3=16'h0000.
  - in_ready=1 after reset for any s, since all FIFOs are empty.
- Latency: a byte accepted at rising edge k into an empty FIFO is visible on yi with y_valid[i]=1 in the cycle after edge k.
- Throughput: one byte per cycle per channel when DEPTH≥2 and the consumer keeps y_ready high.
- Reset asserted mid-operation clears all FIFOs at once, discarding contents. Handshakes in flight during reset are lost.
- Release of reset is synchronised externally. The block does not accept data in the cycle in which reset is high.

## Configuration
- Macro DEMUX48_STATS_EN.
- Defined:
  - Ports cnt0..cnt3 exist.
  - cnti increments by 1 on every push to channel i.
  - Counters saturate at 16'hFFFF; they do not wrap.
  - Cleared only by reset.
- Undefined: the counter logic and the cnt ports are absent. All other behaviour is identical.

## Structure
- Package demux48_pkg:
  - DATA_W=8, NCH=4, CNT_W=16.
  - typedef logic [DATA_W-1:0] byte_t.
  - typedef logic [1:0] sel_t.
- Sub-module demux48_fifo: one synchronous FIFO with parameter DEPTH.
  - Ports: clk, reset, push, din, full, pop, dout, empty.
  - Instantiated four times in a generate loop. The top level holds only the steering and handshake logic plus the optional counters.

## Test plan
- Reset then single byte: s=2, d=8'hA5, in_valid for one cycle, y_ready=4'b1111 → next cycle y2=8'hA5, y_valid=4'b0100; the cycle after, y_valid=0.
- Back-pressure, DEPTH=2: y_ready[1]=0, push 8'h11, 8'h22, 8'h33 to s=1 → in_ready drops after 8'h22.
  - Raise y_ready[1]: y1 shows 8'h11, then 8'h22, then 8'h33 after it is accepted.
- Isolation: channel 0 full and stalled; push 8'h5A to s=3 → accepted immediately, y3=8'h5A the next cycle.
- Full + pop same cycle: channel 0 full, y_ready[0]=1, push to s=0 → push refused that cycle and accepted the next. The order 8'h01, 8'h02, 8'h03 is preserved.
- Reset mid-stream: three channels non-empty, assert reset → y_valid=0 and in_ready=1 immediately. No stale data appears after release.
- With DEMUX48_STATS_EN: 70000 pushes to s=0 with y_ready=1 → cnt0=16'hFFFF; cnt1..cnt3=0.

Source files
------------

// File: rtl/demux48_pkg.sv
// rtl/demux48_pkg.sv - shared widths, types and helpers for the demux48 byte distributor
package demux48_pkg;

   localparam int DATA_W = 8;
   localparam int NCH    = 4;
   localparam int CNT_W  = 16;

   typedef logic [DATA_W-1:0] byte_t;
   typedef logic [1:0]        sel_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == '1) ? c : c + cnt_t'(1);
   endfunction

endpackage

// File: rtl/demux48_fifo.sv
// rtl/demux48_fifo.sv - single-channel synchronous FIFO with wrap-bit pointers
// DEPTH must be a power of two, at least 2.
module demux48_fifo
   import demux48_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  push,
   input  byte_t din,
   output logic  full,
   input  logic  pop,
   output byte_t dout,
   output logic  empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   byte_t         mem [DEPTH];
   logic [AW:0]   ptr_one;

   assign ptr_one = {{AW{1'b0}}, 1'b1};

   // One extra pointer bit separates full from empty when the indices match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + ptr_one;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + ptr_one;
         end
      end
   end

endmodule

// File: rtl/demux48_stream.sv
// rtl/demux48_stream.sv - 1-to-4 byte distributor with per-channel FIFOs
// Optional per-channel accepted-byte counters under DEMUX48_STATS_EN.
module demux48_stream
   import demux48_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  byte_t      d,
   input  sel_t       s,
   input  logic       in_valid,
   output logic       in_ready,
   output byte_t      y0,
   output byte_t      y1,
   output byte_t      y2,
   output byte_t      y3,
   output logic [3:0] y_valid,
`ifdef DEMUX48_STATS_EN
   input  logic [3:0] y_ready,
   output cnt_t       cnt0,
   output cnt_t       cnt1,
   output cnt_t       cnt2,
   output cnt_t       cnt3
`else
   input  logic [3:0] y_ready
`endif
);

   logic [NCH-1:0] full;
   logic [NCH-1:0] empty;
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;
   byte_t          dout [NCH];

   // Acceptance looks only at the addressed FIFO's registered state, so a
   // same-cycle pop on a full channel never frees room for this push.
   assign in_ready = !full[s];

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign push[gi] = in_valid && in_ready && (s == sel_t'(gi));
         assign pop[gi]  = !empty[gi] && y_ready[gi];

         demux48_fifo #(
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[gi]),
            .din   (d),
            .full  (full[gi]),
            .pop   (pop[gi]),
            .dout  (dout[gi]),
            .empty (empty[gi])
         );
      end
   endgenerate

   assign y_valid = ~empty;
   assign y0      = dout[0];
   assign y1      = dout[1];
   assign y2      = dout[2];
   assign y3      = dout[3];

`ifdef DEMUX48_STATS_EN
   cnt_t cnt_r [NCH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (push[i]) begin
               cnt_r[i] <= sat_inc(cnt_r[i]);
            end
         end
      end
   end

   assign cnt0 = cnt_r[0];
   assign cnt1 = cnt_r[1];
   assign cnt2 = cnt_r[2];
   assign cnt3 = cnt_r[3];
`endif

endmodule

// File: tb/tb_demux48_stream.sv
// tb/tb_demux48_stream.sv - self-checking bench for demux48_stream (queue model plus directed vectors)
// Counter checks are compiled in with DEMUX48_STATS_EN.
module tb_demux48_stream;

   localparam int DEPTH = 2;

   logic       clk;
   logic       reset;
   logic [7:0] d;
   logic [1:0] s;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] y0, y1, y2, y3;
   logic [3:0] y_valid;
   logic [3:0] y_ready;
   logic [7:0] ys [4];
`ifdef DEMUX48_STATS_EN
   logic [15:0] cnt0, cnt1, cnt2, cnt3;
   logic [15:0] cs [4];
`endif

   int tests = 0;
   int fails = 0;

   demux48_stream #(
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .d        (d),
      .s        (s),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .y_valid  (y_valid),
`ifdef DEMUX48_STATS_EN
      .y_ready  (y_ready),
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .cnt2     (cnt2),
      .cnt3     (cnt3)
`else
      .y_ready  (y_ready)
`endif
   );

   assign ys[0] = y0;
   assign ys[1] = y1;
   assign ys[2] = y2;
   assign ys[3] = y3;
`ifdef DEMUX48_STATS_EN
   assign cs[0] = cnt0;
   assign cs[1] = cnt1;
   assign cs[2] = cnt2;
   assign cs[3] = cnt3;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: one ordered queue per channel, capacity DEPTH, plus saturating push counts.
   logic [7:0]  q [4][$];
   int unsigned mcnt [4];
   int          sz [4];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            q[i].delete();
            mcnt[i] = 0;
         end
      end else begin
         for (int i = 0; i < 4; i++) sz[i] = q[i].size();
         for (int i = 0; i < 4; i++) begin
            if (sz[i] > 0 && y_ready[i]) void'(q[i].pop_front());
         end
         if (in_valid && sz[s] < DEPTH) begin
            q[s].push_back(d);
            if (mcnt[s] < 65535) mcnt[s]++;
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready_model", {31'd0, in_ready}, {31'd0, q[s].size() < DEPTH});
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("y_valid_model[%0d]", i), {31'd0, y_valid[i]}, {31'd0, q[i].size() != 0});
         if (q[i].size() != 0) chk($sformatf("y_data_model[%0d]", i), {24'd0, ys[i]}, {24'd0, q[i][0]});
`ifdef DEMUX48_STATS_EN
         chk($sformatf("cnt_model[%0d]", i), {16'd0, cs[i]}, mcnt[i]);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] tp_s [8] = '{2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
   logic [7:0] tp_d [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};

   initial begin
      reset    = 1'b1;
      d        = 8'h00;
      s        = 2'd0;
      in_valid = 1'b0;
      y_ready  = 4'b1111;
      repeat (3) step();

      chk("reset_y_valid", {28'd0, y_valid}, 32'h0);
      chk("reset_y0", {24'd0, y0}, 32'h0);
      chk("reset_y3", {24'd0, y3}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         s = 2'(i);
         #1;
         chk("reset_in_ready", {31'd0, in_ready}, 32'h1);
      end
`ifdef DEMUX48_STATS_EN
      chk("reset_cnt0", {16'd0, cnt0}, 32'h0);
`endif
      reset = 1'b0;
      step();

      // Single byte to channel 2
      s = 2'd2; d = 8'hA5; in_valid = 1'b1; y_ready = 4'b1111;
      step();
      in_valid = 1'b0;
      chk("single_y_valid", {28'd0, y_valid}, 32'h4);
      chk("single_y2", {24'd0, y2}, 32'hA5);
      step();
      chk("single_drain", {28'd0, y_valid}, 32'h0);

      // Back-pressure on channel 1
      y_ready = 4'b1101; s = 2'd1; d = 8'h11; in_valid = 1'b1;
      #1 chk("bp_ready_first", {31'd0, in_ready}, 32'h1);
      step();
      d = 8'h22;
      step();
      d = 8'h33;
      chk("bp_ready_drop", {31'd0, in_ready}, 32'h0);
      chk("bp_head_11", {24'd0, y1}, 32'h11);
      y_ready = 4'b1111;
      step();
      chk("bp_head_22", {24'd0, y1}, 32'h22);
      chk("bp_ready_back", {31'd0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      chk("bp_head_33", {24'd0, y1}, 32'h33);
      step();
      chk("bp_empty", {28'd0, y_valid}, 32'h0);

      // Isolation: channel 0 full and stalled, channel 3 still flows
      y_ready = 4'b0000; s = 2'd0; in_valid = 1'b1;
      d = 8'h01; step();
      d = 8'h02; step();
      chk("iso_ch0_full", {31'd0, in_ready}, 32'h0);
      s = 2'd3; d = 8'h5A;
      #1 chk("iso_ready_ch3", {31'd0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      chk("iso_y3", {24'd0, y3}, 32'h5A);
      chk("iso_y_valid", {28'd0, y_valid}, 32'h9);
      y_ready = 4'b1000;
      step();

      // Full channel with a pop in the same cycle still refuses the push
      y_ready = 4'b0001; s = 2'd0; d = 8'h03; in_valid = 1'b1;
      #1 chk("fp_refused", {31'd0, in_ready}, 32'h0);
      step();
      chk("fp_head_02", {24'd0, y0}, 32'h02);
      chk("fp_ready_next", {31'd0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      chk("fp_head_03", {24'd0, y0}, 32'h03);
      step();
      chk("fp_empty", {28'd0, y_valid}, 32'h0);

      // Back-to-back stream across channels
      y_ready = 4'b1111; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s = tp_s[k]; d = tp_d[k];
         #1 chk("tp_ready", {31'd0, in_ready}, 32'h1);
         step();
      end
      in_valid = 1'b0;
      step();

      // Reset mid-stream
      y_ready = 4'b0000; in_valid = 1'b1;
      s = 2'd0; d = 8'hC0; step();
      d = 8'hC1; step();
      s = 2'd1; d = 8'hC2; step();
      s = 2'd2; d = 8'hC3; step();
      s = 2'd0;
      #1 chk("mid_pre_ready", {31'd0, in_ready}, 32'h0);
      chk("mid_pre_valid", {28'd0, y_valid}, 32'h7);
      reset = 1'b1;
      #1;
      chk("mid_valid_clear", {28'd0, y_valid}, 32'h0);
      chk("mid_ready_set", {31'd0, in_ready}, 32'h1);
      chk("mid_y0_clear", {24'd0, y0}, 32'h0);
      step();
      step();
      in_valid = 1'b0;
      reset = 1'b0;
      step();
      chk("mid_no_stale", {28'd0, y_valid}, 32'h0);

`ifdef DEMUX48_STATS_EN
      // Saturation of counter 0
      s = 2'd0; d = 8'h77; y_ready = 4'b1111; in_valid = 1'b1;
      repeat (70000) step();
      in_valid = 1'b0;
      step();
      chk("sat_cnt0", {16'd0, cnt0}, 32'hFFFF);
      chk("sat_cnt1", {16'd0, cnt1}, 32'h0);
      chk("sat_cnt2", {16'd0, cnt2}, 32'h0);
      chk("sat_cnt3", {16'd0, cnt3}, 32'h0);
`endif

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
